dmem_lsu_32: RTL and testbench
==============================

// Module: dmem_lsu_32
// PURPOSE
//  Load/store initiator for the 32-bit byte-lane data memory (4 byte banks, 1-cycle registered read).
//  Accepts one RV32 load/store per handshake from the core.
//  Generates byte enables, lane-replicated write data and word address, and waits for read data.
//  Aligns and sign/zero-extends load data, and returns a single response pulse with error status.
// PARAMETERS
//  ADDR_W   15  byte-address width of memory port (= $clog2(DEPTH)+2, DEPTH=8192)
//  TIMEOUT  16  max cycles in RD_WAIT without mem_read_data_valid before timeout error
// PORTS
//  clk                  in   1       single clock, all state on posedge
//  reset                in   1       asynchronous, active-high; clears all state
//  lsu_req_valid        in   1       core request valid
//  lsu_req_ready        out  1       block can accept (high only in IDLE, low while reset asserted)
//  lsu_req_we           in   1       1=store, 0=load
//  lsu_req_funct3       in   3       RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  lsu_req_addr         in   32      byte address
//  lsu_req_wdata        in   32      store data (LSBs significant)
//  lsu_resp_valid       out  1       one-cycle response pulse
//  lsu_resp_rdata       out  32      extended load data; 0 for stores and errors
//  lsu_resp_err         out  3       000 ok, 001 misaligned, 010 out-of-range, 011 illegal funct3, 100 timeout
//  mem_read_cmd_valid   out  1       read command, one-cycle pulse
//  mem_write_cmd_valid  out  1       write command, one-cycle pulse
//  mem_write_data_valid out  1       asserted identically to mem_write_cmd_valid
//  mem_addr             out  ADDR_W  word-aligned byte address {addr[ADDR_W-1:2],2'b00}
//  mem_write_data       out  32      lane-replicated store data
//  mem_write_data_size  out  4       byte enables, bit i = byte lane i
//  mem_read_data        in   32      memory read word
//  mem_read_data_valid  in   1       memory read data valid
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, including rdata/err/mem_* and the timeout counter.
//    lsu_req_ready rises in the first cycle after reset deasserts.
//  - Accept: lsu_req_valid && lsu_req_ready at a posedge.
//    we/funct3/addr/wdata are captured at acceptance; core inputs are don't-care afterwards.
//  - FSM transitions:
//    IDLE -> ISSUE on accept with no error.
//    IDLE -> RESP on accept with an error; no mem command is issued.
//    ISSUE -> RESP for a store; ISSUE -> RD_WAIT for a load.
//    RD_WAIT -> RESP on mem_read_data_valid, or when the counter reaches TIMEOUT.
//    RESP -> IDLE.
//  - ISSUE (exactly 1 cycle): drive mem_addr and mem_write_data_size.
//    Store: mem_write_cmd_valid=mem_write_data_valid=1. Load: mem_read_cmd_valid=1, size=0000.
//    All cmd/valid outputs are 0 in every other state.
//  - Error checks at accept, in priority order:
//    1. Illegal funct3: load not in {000,001,010,100,101}; store not in {000,001,010}.
//    2. Out-of-range: addr[31:ADDR_W] != 0.
//    3. Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//  - Byte enables (o = addr[1:0]):
//    byte: 4'b0001<<o; half: 4'b0011<<o; word: 4'b1111.
//  - Write data replication:
//    SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
//  - Load alignment: sh = mem_read_data >> (8*o).
//    LB sext(sh[7:0]); LBU zext(sh[7:0]); LH sext(sh[15:0]); LHU zext(sh[15:0]); LW sh.
//  - Load data is registered on the mem_read_data_valid cycle.
//  - RESP: lsu_resp_valid=1 for exactly one cycle with rdata/err.
//    rdata/err hold until the next RESP; resp_valid=0 otherwise.
//  - Latency (accept edge = cycle 0):
//    Store: ISSUE in cycle 1, resp_valid in cycle 2.
//    Load, 1-cycle memory: ISSUE cycle 1, mem_read_data_valid cycle 2, resp_valid cycle 3.
//    Error: resp_valid in cycle 1.
//    Back-to-back: next accept is possible in the cycle after RESP.
//  - Timeout: counter clears on entering RD_WAIT and increments each RD_WAIT cycle.
//    At TIMEOUT the block enters RESP with err=100, rdata=0.
//  - mem_read_data_valid outside RD_WAIT (stray or late) is ignored.
//    A timed-out read's late data is dropped.
//  - Reset mid-operation: pending request is aborted with no response; cmd outputs drop immediately.
// TESTING
//  1. SW addr=0x0010 wdata=0xDEADBEEF -> ISSUE cycle 1: mem_addr=0x0010, size=1111, write_data=0xDEADBEEF; resp_valid cycle 2, err=000.
//  2. SB addr=0x0013 wdata=0x000000A5 -> size=1000, write_data=0xA5A5A5A5; then LB addr=0x0013 on word 0xA5000000 -> rdata=0xFFFFFFA5; LBU -> 0x000000A5.
//  3. LH addr=0x0022 with memory word 0x80017FFF -> rdata=0xFFFF8001; LHU -> 0x00008001; response in cycle 3.
//  4. LW addr=0x0006 -> err=001, resp cycle 1, no mem cmd.
//     LW addr=0x00008000 (ADDR_W=15) -> err=010.
//     Load funct3=011 -> err=011.
//  5. Load with memory model never asserting read_data_valid -> resp_valid after TIMEOUT cycles in RD_WAIT, err=100, rdata=0; later stray valid ignored.
//  6. Assert reset while in RD_WAIT -> all outputs 0 at once, no resp_valid; after release ready=1 and a new SW completes normally.

Source files
------------

// File: rtl/dmem_lsu_32.sv
// Load/store initiator for a 32-bit, 4-bank byte-lane data memory with a 1-cycle registered read.
// Takes one RV32 load/store per handshake and returns one response pulse carrying data and an error code.
module dmem_lsu_32 #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_we,
  input  logic [2:0]        lsu_req_funct3,
  input  logic [31:0]       lsu_req_addr,
  input  logic [31:0]       lsu_req_wdata,
  output logic              lsu_resp_valid,
  output logic [31:0]       lsu_resp_rdata,
  output logic [2:0]        lsu_resp_err,
  output logic              mem_read_cmd_valid,
  output logic              mem_write_cmd_valid,
  output logic              mem_write_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_write_data_size,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_read_data_valid
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ERR_OK       = 3'b000;
  localparam logic [2:0] ERR_MISALIGN = 3'b001;
  localparam logic [2:0] ERR_RANGE    = 3'b010;
  localparam logic [2:0] ERR_FUNCT3   = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               req_we, req_we_nxt;
  logic [2:0]         req_funct3, req_funct3_nxt;
  logic [1:0]         req_off, req_off_nxt;

  logic               ready_nxt, resp_valid_nxt, rd_cmd_nxt, wr_cmd_nxt;
  logic [31:0]        rdata_nxt, wdata_nxt;
  logic [2:0]         err_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [3:0]         size_nxt;

  logic               accept;
  logic               funct3_ok;
  logic [2:0]         req_err;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_rep;
  logic [31:0]        rd_shift;
  logic [31:0]        load_data;
  logic [CNT_W-1:0]   cnt_inc;

  assign accept  = lsu_req_valid && lsu_req_ready;
  assign cnt_inc = cnt + CNT_W'(1);

  // Request decode: error classification, byte enables and lane replication from live core inputs
  always_comb begin
    funct3_ok = 1'b0;
    req_err   = ERR_OK;
    byte_en   = 4'b1111;
    wdata_rep = lsu_req_wdata;
    if (lsu_req_we) funct3_ok = (lsu_req_funct3 == 3'b000) || (lsu_req_funct3 == 3'b001) ||
                                (lsu_req_funct3 == 3'b010);
    else            funct3_ok = (lsu_req_funct3 == 3'b000) || (lsu_req_funct3 == 3'b001) ||
                                (lsu_req_funct3 == 3'b010) || (lsu_req_funct3 == 3'b100) ||
                                (lsu_req_funct3 == 3'b101);
    if (!funct3_ok)                             req_err = ERR_FUNCT3;
    else if ((lsu_req_addr >> ADDR_W) != 32'd0) req_err = ERR_RANGE;
    else if ((lsu_req_funct3[1:0] == 2'b01 && lsu_req_addr[0]) ||
             (lsu_req_funct3[1:0] == 2'b10 && lsu_req_addr[1:0] != 2'b00))
                                                req_err = ERR_MISALIGN;
    case (lsu_req_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << lsu_req_addr[1:0];
        wdata_rep = {4{lsu_req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = 4'b0011 << lsu_req_addr[1:0];
        wdata_rep = {2{lsu_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and extension using the captured offset and funct3
  always_comb begin
    rd_shift = mem_read_data >> {req_off, 3'b000};
    case (req_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Next state and next values of every registered output
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    req_we_nxt     = req_we;
    req_funct3_nxt = req_funct3;
    req_off_nxt    = req_off;
    resp_valid_nxt = 1'b0;
    rdata_nxt      = lsu_resp_rdata;
    err_nxt        = lsu_resp_err;
    rd_cmd_nxt     = 1'b0;
    wr_cmd_nxt     = 1'b0;
    addr_nxt       = '0;
    wdata_nxt      = '0;
    size_nxt       = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_we_nxt     = lsu_req_we;
          req_funct3_nxt = lsu_req_funct3;
          req_off_nxt    = lsu_req_addr[1:0];
          if (req_err != ERR_OK) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            rdata_nxt      = '0;
            err_nxt        = req_err;
          end else begin
            state_nxt = ISSUE;
            addr_nxt  = {lsu_req_addr[ADDR_W-1:2], 2'b00};
            if (lsu_req_we) begin
              wr_cmd_nxt = 1'b1;
              size_nxt   = byte_en;
              wdata_nxt  = wdata_rep;
            end else begin
              rd_cmd_nxt = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (req_we) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          rdata_nxt      = '0;
          err_nxt        = ERR_OK;
        end else begin
          state_nxt = RD_WAIT;
          cnt_nxt   = '0;
        end
      end
      RD_WAIT: begin
        if (mem_read_data_valid) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          rdata_nxt      = load_data;
          err_nxt        = ERR_OK;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          rdata_nxt      = '0;
          err_nxt        = ERR_TIMEOUT;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      req_we               <= 1'b0;
      req_funct3           <= '0;
      req_off              <= '0;
      lsu_req_ready        <= 1'b0;
      lsu_resp_valid       <= 1'b0;
      lsu_resp_rdata       <= '0;
      lsu_resp_err         <= '0;
      mem_read_cmd_valid   <= 1'b0;
      mem_write_cmd_valid  <= 1'b0;
      mem_write_data_valid <= 1'b0;
      mem_addr             <= '0;
      mem_write_data       <= '0;
      mem_write_data_size  <= '0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      req_we               <= req_we_nxt;
      req_funct3           <= req_funct3_nxt;
      req_off              <= req_off_nxt;
      lsu_req_ready        <= ready_nxt;
      lsu_resp_valid       <= resp_valid_nxt;
      lsu_resp_rdata       <= rdata_nxt;
      lsu_resp_err         <= err_nxt;
      mem_read_cmd_valid   <= rd_cmd_nxt;
      mem_write_cmd_valid  <= wr_cmd_nxt;
      mem_write_data_valid <= wr_cmd_nxt;
      mem_addr             <= addr_nxt;
      mem_write_data       <= wdata_nxt;
      mem_write_data_size  <= size_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_lsu_32.sv
// Bench for dmem_lsu_32: 1-cycle byte-lane memory model plus a byte-array reference model
// for expected load data, error codes, latency and store lane enables.
module tb_dmem_lsu_32;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              lsu_req_valid = 1'b0;
  logic              lsu_req_ready;
  logic              lsu_req_we = 1'b0;
  logic [2:0]        lsu_req_funct3 = '0;
  logic [31:0]       lsu_req_addr = '0;
  logic [31:0]       lsu_req_wdata = '0;
  logic              lsu_resp_valid;
  logic [31:0]       lsu_resp_rdata;
  logic [2:0]        lsu_resp_err;
  logic              mem_read_cmd_valid;
  logic              mem_write_cmd_valid;
  logic              mem_write_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_write_data_size;
  logic [31:0]       mem_read_data = '0;
  logic              mem_read_data_valid = 1'b0;

  dmem_lsu_32 #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_funct3(lsu_req_funct3), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_read_cmd_valid(mem_read_cmd_valid), .mem_write_cmd_valid(mem_write_cmd_valid),
    .mem_write_data_valid(mem_write_data_valid), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write_data_size(mem_write_data_size),
    .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tb_mem [8192];
  logic [7:0]  ref_mem [32768];
  logic        mem_en = 1'b1;
  logic        stray  = 1'b0;

  // Memory model: registered read one cycle after a read command, byte-enabled writes
  always @(posedge clk) begin
    mem_read_data_valid <= 1'b0;
    if (mem_read_cmd_valid && mem_en) begin
      mem_read_data_valid <= 1'b1;
      mem_read_data       <= tb_mem[mem_addr[ADDR_W-1:2]];
    end
    if (stray) begin
      mem_read_data_valid <= 1'b1;
      mem_read_data       <= $urandom;
    end
    if (mem_write_cmd_valid)
      for (int i = 0; i < 4; i++)
        if (mem_write_data_size[i]) tb_mem[mem_addr[ADDR_W-1:2]][8*i +: 8] = mem_write_data[8*i +: 8];
  end

  logic [31:0]       obs_rd, obs_wd;
  logic [2:0]        obs_er;
  logic [3:0]        obs_be;
  logic [ADDR_W-1:0] obs_addr;
  logic              obs_rdc, obs_wrc, obs_wdv_bad;
  int                obs_lat, obs_cmd;

  // Reference: byte-level memory and the architectural load/store rules
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic [2:0] er);
    int n;
    logic legal;
    logic [63:0] val;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    rd = '0;
    if (!legal)                    er = 3'd3;
    else if (addr >= 32'h8000)     er = 3'd2;
    else if ((addr % n) != 0)      er = 3'd1;
    else                           er = 3'd0;
    if (er == 3'd0 && !we) begin
      val = '0;
      for (int i = 0; i < n; i++) val = val | (64'(ref_mem[addr + i]) << (8 * i));
      if (!f3[2] && n < 4 && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      rd = val[31:0];
    end
    if (er == 3'd0 && we)
      for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(wd >> (8 * i));
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return {4{wd[7:0]}};
    if (f3[1:0] == 2'd1) return {2{wd[15:0]}};
    return wd;
  endfunction

  // Drives one request and records what the DUT did until its response (obs_lat = -1 if none)
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int k;
    obs_lat = -1; obs_cmd = 0; obs_wdv_bad = 1'b0; obs_rd = '0; obs_er = '0;
    k = 0;
    while (!lsu_req_ready && k < 20) begin @(negedge clk); k++; end
    if (!lsu_req_ready) return;
    lsu_req_valid = 1'b1; lsu_req_we = we; lsu_req_funct3 = f3; lsu_req_addr = addr; lsu_req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        lsu_req_valid = 1'b0; lsu_req_we = 1'($urandom); lsu_req_funct3 = 3'($urandom);
        lsu_req_addr = $urandom; lsu_req_wdata = $urandom;
        obs_addr = mem_addr; obs_be = mem_write_data_size; obs_wd = mem_write_data;
        obs_rdc = mem_read_cmd_valid; obs_wrc = mem_write_cmd_valid;
      end
      if (mem_read_cmd_valid || mem_write_cmd_valid) obs_cmd++;
      if (mem_write_data_valid !== mem_write_cmd_valid) obs_wdv_bad = 1'b1;
      if (lsu_resp_valid) begin
        obs_rd = lsu_resp_rdata; obs_er = lsu_resp_err; obs_lat = c;
        break;
      end
    end
  endtask

  // Runs a request through both DUT and model and compares response, latency and command count
  task automatic check_req(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] erd;
    logic [2:0]  eer;
    int          elat;
    model(we, f3, addr, wd, erd, eer);
    elat = (eer != 3'd0) ? 1 : we ? 2 : 3;
    run_req(we, f3, addr, wd);
    n_tests++; if (obs_lat != elat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, obs_lat, elat); end
    n_tests++; if (obs_er !== eer) begin n_fail++; $display("FAIL %s err got %b want %b", name, obs_er, eer); end
    n_tests++; if (obs_rd !== erd) begin n_fail++; $display("FAIL %s rdata got %h want %h", name, obs_rd, erd); end
    n_tests++; if (obs_cmd != ((eer == 3'd0) ? 1 : 0)) begin n_fail++; $display("FAIL %s cmd_cycles got %0d want %0d", name, obs_cmd, (eer == 3'd0) ? 1 : 0); end
    n_tests++; if (obs_wdv_bad) begin n_fail++; $display("FAIL %s write_data_valid got mismatch want equal to write_cmd_valid", name); end
    if (eer == 3'd0) begin
      n_tests++; if (obs_addr !== ADDR_W'(addr & 32'h7FFC)) begin n_fail++; $display("FAIL %s mem_addr got %h want %h", name, obs_addr, addr & 32'h7FFC); end
      n_tests++; if ({obs_rdc, obs_wrc} !== {!we, we}) begin n_fail++; $display("FAIL %s cmd_kind got %b want %b", name, {obs_rdc, obs_wrc}, {!we, we}); end
      n_tests++; if (obs_be !== (we ? exp_be(f3, addr) : 4'd0)) begin n_fail++; $display("FAIL %s byte_en got %b want %b", name, obs_be, we ? exp_be(f3, addr) : 4'd0); end
      if (we) begin
        n_tests++; if (obs_wd !== exp_wd(f3, wd)) begin n_fail++; $display("FAIL %s write_data got %h want %h", name, obs_wd, exp_wd(f3, wd)); end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, mem_read_cmd_valid, mem_write_cmd_valid,
         mem_write_data_valid, mem_addr, mem_write_data, mem_write_data_size} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero want all zero");
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", lsu_req_ready); end
  endtask

  task automatic test_directed;
    check_req("sw_0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check_req("sb_0x13", 1'b1, 3'b000, 32'h13, 32'h000000A5);
    check_req("lb_0x13", 1'b0, 3'b000, 32'h13, 32'h0);
    check_req("lbu_0x13", 1'b0, 3'b100, 32'h13, 32'h0);
    check_req("sw_0x20", 1'b1, 3'b010, 32'h20, 32'h80017FFF);
    check_req("lh_0x22", 1'b0, 3'b001, 32'h22, 32'h0);
    check_req("lhu_0x22", 1'b0, 3'b101, 32'h22, 32'h0);
    check_req("lw_misaligned", 1'b0, 3'b010, 32'h6, 32'h0);
    check_req("lw_range", 1'b0, 3'b010, 32'h8000, 32'h0);
    check_req("ld_funct3_011", 1'b0, 3'b011, 32'h10, 32'h0);
    check_req("st_funct3_100", 1'b1, 3'b100, 32'h10, 32'h0);
    check_req("range_over_misalign", 1'b0, 3'b010, 32'h8002, 32'h0);
    check_req("funct3_over_range", 1'b1, 3'b111, 32'hFFFF0000, 32'h0);
    check_req("lw_top_word", 1'b0, 3'b010, 32'h7FFC, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int t = 0; t < 200; t++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(15, 31));
      check_req("random", 1'($urandom), 3'($urandom), a, $urandom);
    end
  endtask

  task automatic test_back_to_back;
    check_req("b2b_sw", 1'b1, 3'b010, 32'h30, 32'h12345678);
    @(negedge clk);
    n_tests++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", lsu_req_ready); end
    n_tests++; if (lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_resp_pulse got %b want 0", lsu_resp_valid); end
    check_req("b2b_lw", 1'b0, 3'b010, 32'h30, 32'h0);
  endtask

  task automatic test_timeout;
    mem_en = 1'b0;
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    n_tests++; if (obs_lat != 2 + TIMEOUT) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", obs_lat, 2 + TIMEOUT); end
    n_tests++; if (obs_er !== 3'b100) begin n_fail++; $display("FAIL timeout_err got %b want 100", obs_er); end
    n_tests++; if (obs_rd !== 32'd0) begin n_fail++; $display("FAIL timeout_rdata got %h want 0", obs_rd); end
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_resp got %b want 0", lsu_resp_valid); end
    end
    n_tests++; if (lsu_resp_err !== 3'b100) begin n_fail++; $display("FAIL stray_err_hold got %b want 100", lsu_resp_err); end
    mem_en = 1'b1;
    check_req("after_timeout_lw", 1'b0, 3'b010, 32'h10, 32'h0);
  endtask

  task automatic test_reset_mid;
    mem_en = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_funct3 = 3'b010; lsu_req_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, mem_read_cmd_valid, mem_write_cmd_valid,
         mem_write_data_valid, mem_addr, mem_write_data, mem_write_data_size} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs got nonzero want all zero");
    end
    mem_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if (lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_resp got %b want 0", lsu_resp_valid); end
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready got %b want 1", lsu_req_ready); end
    check_req("after_reset_sw", 1'b1, 3'b010, 32'h44, 32'hCAFEF00D);
    check_req("after_reset_lw", 1'b0, 3'b010, 32'h44, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    for (int w = 0; w < 8192; w++) begin
      v = $urandom;
      tb_mem[w] = v;
      for (int i = 0; i < 4; i++) ref_mem[4*w + i] = v[8*i +: 8];
    end
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
